// File: rtl/multih_pkg.sv
// Shared constants and FSM encoding for the multi-h trellis decoder blocks.
package multih_pkg;

    localparam int METRIC_W   = 8;
    localparam int MAX_STATES = 64;
    localparam int IDX_W      = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } scan_state_t;

endpackage

// File: rtl/max4_signed.sv
// Combinational signed 4-input max; ties resolve to the lowest lane.
module max4_signed #(
    parameter int W = 8
) (
    input  logic [4*W-1:0]        lanes,
    output logic [1:0]            max_lane,
    output logic signed [W-1:0]   max_val
);

    logic signed [W-1:0] lane_val [4];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_val[gi] = lanes[gi*W +: W];
        end
    endgenerate

    logic                lo_sel, hi_sel;
    logic signed [W-1:0] lo_val, hi_val;

    // Strict greater-than at every stage keeps the lower lane on ties.
    always_comb begin
        lo_sel = (lane_val[1] > lane_val[0]);
        lo_val = lo_sel ? lane_val[1] : lane_val[0];
        hi_sel = (lane_val[3] > lane_val[2]);
        hi_val = hi_sel ? lane_val[3] : lane_val[2];
        if (hi_val > lo_val) begin
            max_lane = {1'b1, hi_sel};
            max_val  = hi_val;
        end else begin
            max_lane = {1'b0, lo_sel};
            max_val  = lo_val;
        end
    end

endmodule

// File: rtl/multih_best_state_search.sv
// Scans the path-metric RAM four states per cycle and reports the best state.
// Optional normalization request output is enabled with MULTIH_NORM_EN.
module multih_best_state_search
    import multih_pkg::*;
#(
    parameter int SIZE       = METRIC_W,
    parameter int NUM_STATES = MAX_STATES,
    parameter logic signed [SIZE-1:0] NORM_THRESH = SIZE'(64)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    output logic                 rdEn,
    output logic [3:0]           rdAddr,
    input  logic [4*SIZE-1:0]    rdData,
    output logic                 busy,
    output logic                 done,
    output logic [IDX_W-1:0]     bestIndex,
    output logic [SIZE-1:0]      bestMetric
`ifdef MULTIH_NORM_EN
    ,
    output logic                 normReq,
    output logic [SIZE-1:0]      normOffset
`endif
);

    localparam int         G         = NUM_STATES / 4;
    localparam logic [3:0] LAST_ADDR = 4'(G - 1);

    scan_state_t            state_q, state_d;
    logic                   rd_en_q, rd_en_d;
    logic [3:0]             rd_addr_q, rd_addr_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [IDX_W-1:0]       best_idx_q, best_idx_d;
    logic signed [SIZE-1:0] best_metric_q, best_metric_d;
    logic                   data_vld_q, data_vld_d;
    logic [3:0]             data_grp_q, data_grp_d;
    logic signed [SIZE-1:0] run_max_q, run_max_d;
    logic [IDX_W-1:0]       run_idx_q, run_idx_d;
    logic                   first_q, first_d;
    logic                   norm_req_q, norm_req_d;
    logic signed [SIZE-1:0] norm_off_q, norm_off_d;

    logic [1:0]             lane_sel;
    logic signed [SIZE-1:0] lane_max;
    logic                   cand_better;
    logic signed [SIZE-1:0] scan_max;
    logic [IDX_W-1:0]       scan_idx;

    max4_signed #(.W(SIZE)) u_max4 (
        .lanes    (rdData),
        .max_lane (lane_sel),
        .max_val  (lane_max)
    );

    // The first beat of a scan seeds the running max regardless of its value.
    always_comb begin
        cand_better = first_q || (lane_max > run_max_q);
        scan_max    = cand_better ? lane_max : run_max_q;
        scan_idx    = cand_better ? IDX_W'({data_grp_q, lane_sel}) : run_idx_q;
    end

    always_comb begin
        state_d       = state_q;
        rd_en_d       = rd_en_q;
        rd_addr_d     = rd_addr_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        best_idx_d    = best_idx_q;
        best_metric_d = best_metric_q;
        data_vld_d    = rd_en_q;
        data_grp_d    = rd_addr_q;
        run_max_d     = run_max_q;
        run_idx_d     = run_idx_q;
        first_d       = first_q;
        norm_req_d    = 1'b0;
        norm_off_d    = norm_off_q;

        if (data_vld_q) begin
            run_max_d = scan_max;
            run_idx_d = scan_idx;
            first_d   = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_FETCH;
                    rd_en_d   = 1'b1;
                    rd_addr_d = 4'd0;
                    busy_d    = 1'b1;
                    first_d   = 1'b1;
                end
            end
            ST_FETCH: begin
                if (rd_addr_q == LAST_ADDR) begin
                    rd_en_d = 1'b0;
                    state_d = ST_DRAIN;
                end else begin
                    rd_addr_d = rd_addr_q + 4'd1;
                end
            end
            ST_DRAIN: begin
                // Last group arrives this cycle; publish the merged result directly.
                state_d       = ST_DONE;
                done_d        = 1'b1;
                best_idx_d    = scan_idx;
                best_metric_d = scan_max;
                norm_req_d    = (scan_max >= NORM_THRESH);
                norm_off_d    = scan_max;
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            rd_en_q       <= 1'b0;
            rd_addr_q     <= 4'd0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            best_idx_q    <= '0;
            best_metric_q <= '0;
            data_vld_q    <= 1'b0;
            data_grp_q    <= 4'd0;
            run_max_q     <= '0;
            run_idx_q     <= '0;
            first_q       <= 1'b0;
            norm_req_q    <= 1'b0;
            norm_off_q    <= '0;
        end else begin
            state_q       <= state_d;
            rd_en_q       <= rd_en_d;
            rd_addr_q     <= rd_addr_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            best_idx_q    <= best_idx_d;
            best_metric_q <= best_metric_d;
            data_vld_q    <= data_vld_d;
            data_grp_q    <= data_grp_d;
            run_max_q     <= run_max_d;
            run_idx_q     <= run_idx_d;
            first_q       <= first_d;
            norm_req_q    <= norm_req_d;
            norm_off_q    <= norm_off_d;
        end
    end

    assign rdEn       = rd_en_q;
    assign rdAddr     = rd_addr_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign bestIndex  = best_idx_q;
    assign bestMetric = best_metric_q;

`ifdef MULTIH_NORM_EN
    assign normReq    = norm_req_q;
    assign normOffset = norm_off_q;
`else
    logic unused_norm;
    assign unused_norm = ^{norm_req_q, norm_off_q};
`endif

endmodule

// File: tb/tb_multih_best_state_search.sv
// Directed bench: a behavioural metric RAM feeds the search, each scan is checked.
module tb_multih_best_state_search;

    localparam int NS = 64;
    localparam int G  = NS / 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        rdEn;
    logic [3:0]  rdAddr;
    logic [31:0] rdData = '0;
    logic        busy;
    logic        done;
    logic [5:0]  bestIndex;
    logic [7:0]  bestMetric;
`ifdef MULTIH_NORM_EN
    logic        normReq;
    logic [7:0]  normOffset;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic signed [7:0] mem [NS];

    int lat, ndone, naddr, addr_err, stab_err;
    int norm_seen, norm_off_seen;

    multih_best_state_search #(
        .SIZE(8), .NUM_STATES(NS), .NORM_THRESH(8'sd64)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .rdEn(rdEn), .rdAddr(rdAddr), .rdData(rdData),
        .busy(busy), .done(done),
        .bestIndex(bestIndex), .bestMetric(bestMetric)
`ifdef MULTIH_NORM_EN
        , .normReq(normReq), .normOffset(normOffset)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rdEn) begin
            for (int k = 0; k < 4; k++)
                rdData[k*8 +: 8] <= mem[int'(rdAddr)*4 + k];
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic fill(input int base, input int slope);
        for (int i = 0; i < NS; i++) mem[i] = 8'(base - slope * (i % 20));
    endtask

    // One scan; ex1/ex2 are cycle numbers at which an extra start is sampled.
    task automatic run_scan(input int ex1, input int ex2);
        logic [5:0] prev_idx;
        int exp_addr;
        prev_idx = bestIndex;
        lat = -1; ndone = 0; naddr = 0; addr_err = 0; stab_err = 0; exp_addr = 0;
        norm_seen = 0; norm_off_seen = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int n = 1; n <= G + 8; n++) begin
            if (rdEn) begin
                if (int'(rdAddr) != exp_addr) addr_err++;
                exp_addr++;
                naddr++;
            end
            if (done) begin
                ndone++;
                lat = n;
`ifdef MULTIH_NORM_EN
                norm_seen = int'(normReq);
                norm_off_seen = int'($signed(normOffset));
`endif
            end else if (ndone == 0 && bestIndex != prev_idx) begin
                stab_err++;
            end
            start = (n == ex1 || n == ex2);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic scan_and_check(input string tag, input int exp_idx, input int exp_val,
                                  input int ex1, input int ex2);
        run_scan(ex1, ex2);
        check({tag, " latency"}, lat, G + 2);
        check({tag, " done count"}, ndone, 1);
        check({tag, " rdEn count"}, naddr, G);
        check({tag, " rdAddr order errors"}, addr_err, 0);
        check({tag, " result stable errors"}, stab_err, 0);
        check({tag, " bestIndex"}, int'(bestIndex), exp_idx);
        check({tag, " bestMetric"}, int'($signed(bestMetric)), exp_val);
        $display("[TB] scan %s: idx=%0d metric=%0d latency=%0d", tag, bestIndex,
                 $signed(bestMetric), lat);
    endtask

    initial begin
        fill(0, 0);
        repeat (3) @(negedge clk);
        check("reset rdEn", int'(rdEn), 0);
        check("reset busy", int'(busy), 0);
        reset_n = 1'b1;
        @(negedge clk);
        check("idle rdAddr", int'(rdAddr), 0);
        check("idle done", int'(done), 0);
        check("idle bestIndex", int'(bestIndex), 0);
        check("idle bestMetric", int'(bestMetric), 0);

        fill(0, 0); mem[37] = 8'sd100;
        scan_and_check("single peak", 37, 100, 3, 18);

        fill(-10, 1); mem[5] = -8'sd3; mem[20] = -8'sd128;
        scan_and_check("all negative", 5, -3, 0, 0);

        fill(-10, 1); mem[60] = 8'sd127; mem[2] = -8'sd128;
        scan_and_check("signed extremes", 60, 127, 0, 0);

        fill(0, 0); mem[9] = 8'sd77; mem[50] = 8'sd77;
        scan_and_check("cross-group tie", 9, 77, 0, 0);

        fill(0, 0); mem[12] = 8'sd20; mem[14] = 8'sd20;
        scan_and_check("in-group tie", 12, 20, 0, 0);

        fill(-5, 0); mem[0] = 8'sd0;
        scan_and_check("state 0 best", 0, 0, 0, 0);

        // Abort a scan with reset at cycle 8.
        fill(-50, 1); mem[63] = -8'sd1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (7) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("abort rdEn", int'(rdEn), 0);
        check("abort busy", int'(busy), 0);
        check("abort done", int'(done), 0);
        check("abort rdAddr", int'(rdAddr), 0);
        check("abort bestIndex", int'(bestIndex), 0);
        check("abort bestMetric", int'(bestMetric), 0);
        @(negedge clk); reset_n = 1'b1;
        ndone = 0;
        for (int n = 0; n < G + 6; n++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        check("abort no done", ndone, 0);
        $display("[TB] reset abort: done pulses after reset=%0d", ndone);
        scan_and_check("after abort", 63, -1, 0, 0);

        fill(0, 0); mem[33] = 8'sd70;
        scan_and_check("norm 70", 33, 70, 0, 0);
`ifdef MULTIH_NORM_EN
        check("norm 70 normReq", norm_seen, 1);
        check("norm 70 normOffset", norm_off_seen, 70);
`endif
        fill(0, 0); mem[44] = 8'sd63;
        scan_and_check("norm 63", 44, 63, 0, 0);
`ifdef MULTIH_NORM_EN
        check("norm 63 normReq", norm_seen, 0);
        check("norm 63 normOffset", norm_off_seen, 63);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multih_best_state_search.md
# multih_best_state_search

Sequential best-path-metric search for the multi-h trellis decoder. After each symbol's add-compare-select pass, the block scans the accumulated path-metric RAM four states per cycle. It finds the largest two's-complement metric across all trellis states and reports its state index (0-63) and value to the traceback and metric-normalization logic. It sits directly downstream of the path-metric RAM and applies a 4-way max compare per fetched group.

## Interface
- SIZE, 8: metric width in bits, two's complement.
- NUM_STATES, 64: trellis states scanned; multiple of 4, range 4..64.
- NORM_THRESH, 8'sd64: normalization threshold, signed, SIZE bits; used only when MULTIH_NORM_EN is defined.

- clk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to begin a scan; honoured only in IDLE.
- rdEn  out  1  metric RAM read enable.
- rdAddr  out  4  group address; group g holds states 4g..4g+3.
- rdData  in  4*SIZE  group data, one cycle after rdEn; state 4g+k in bits [(k+1)*SIZE-1 : k*SIZE].
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse; bestIndex and bestMetric are valid from this cycle until the next done.
- bestIndex  out  6  state index of the maximum metric.
- bestMetric  out  SIZE  maximum metric value.
- normReq, normOffset (SIZE)  out  present only with MULTIH_NORM_EN.

## Operation
- States:
  - IDLE: start → FETCH.
  - FETCH: issues rdEn for groups 0..G-1, where G = NUM_STATES/4. After the last address → DRAIN.
  - DRAIN: one cycle to absorb the last read data → DONE.
  - DONE: one cycle, pulses done → IDLE.
- rdAddr increments by 1 each FETCH cycle, starting at 0. It holds at its last value outside FETCH and never wraps past G-1.
- A registered data-valid (rdEn delayed one cycle) qualifies rdData.
- Group compare is a signed compare across the 4 lanes. On ties the lowest lane wins.
- Running compare is against the running max register:
  - The first valid group loads it unconditionally.
  - Later groups replace it only if strictly greater, so ties keep the earlier (lower) index.
- Index = 4*group + lane, 6 bits.
- start while busy is ignored; no queuing.
- bestIndex and bestMetric update only in DONE, so the previous result stays stable during a scan.
- Reset values: state IDLE; rdEn, busy, done, normReq = 0; rdAddr, bestIndex, bestMetric, normOffset = 0.
- Reset asserted mid-scan aborts the scan immediately. No done is produced, and the next start begins a fresh scan from group 0.

## Timing
- start high at edge k:
  - rdEn high in cycles k+1..k+G, with rdAddr = 0..G-1.
  - rdData is valid in cycles k+2..k+G+1.
  - done is high in cycle k+G+2.
- Total latency from start to done is G+2 cycles; 18 for 64 states.
- busy is high in cycles k+1..k+G+2.
- Minimum start-to-start spacing is G+3 cycles. A start in the done cycle is ignored.
- The compare path is a single cycle: combinational 4-way max plus running compare, registered once.

## Configuration
- MULTIH_NORM_EN defined:
  - normReq pulses coincident with done when bestMetric ≥ NORM_THRESH (signed).
  - normOffset = bestMetric, latched at the same edge.
  - This lets the ACS subtract the offset from all metrics before overflow.
- Undefined: normReq and normOffset ports and their logic are absent.

## Structure
- Shared package multih_pkg holds:
  - FSM state encoding (IDLE, FETCH, DRAIN, DONE).
  - Metric width default.
  - The MAX_STATES = 64 constant and index width 6.
- One sub-module, max4_signed:
  - Combinational signed 4-input max.
  - Outputs the 2-bit lane index and the value, with lowest-lane tie priority.
  - Instantiated once.

## Test plan
- Metrics all 0 except state 37 = 8'sd100; start → done at cycle 18, bestIndex = 37, bestMetric = 100.
- All metrics negative, state 5 = -3 and the rest ≤ -10 → bestIndex = 5, bestMetric = -3. Confirms signed compare, with state 60 = 8'sd127 vs state 2 = 8'sh80 (-128) also checked.
- Tie: states 9 and 50 both 8'sd77, others lower → bestIndex = 9. Tie inside one group (states 12 and 14 = 20) → bestIndex = 12.
- start pulsed again at cycles 3 and 18 of a scan → ignored. Exactly one done, with rdAddr sequence 0..15 unbroken.
- reset_n pulsed low at cycle 8 of a scan:
  - All outputs return to 0 and no done is produced.
  - A new start gives the correct result at G+2 cycles.
- With MULTIH_NORM_EN, NORM_THRESH = 64: max 70 → normReq = 1, normOffset = 70. Max 63 → normReq stays 0. NUM_STATES = 16 build gives done at 6 cycles.
